register_read: RTL and testbench

REGISTER_READ -- requirements
Module: register_read

---
 rtl/register_read.sv | 113 +++++++++++
 tb/tb_register_read.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_read.sv
// Register file read stage: 31x32 GPRs with optional write-back forwarding, ID/EX operand
// latch, and load-use hazard detection that inserts single-cycle bubbles.
module register_read #(
  parameter int unsigned BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  Write_register,
  input  logic [31:0] Write_data,
  input  logic        id_valid,
  input  logic [4:0]  Read_register1,
  input  logic [4:0]  Read_register2,
  input  logic        id_MemRead,
  input  logic [4:0]  id_Dest,
  input  logic        flush,
  output logic [31:0] Read_data1,
  output logic [31:0] Read_data2,
  output logic        ex_valid,
  output logic        ex_MemRead,
  output logic [4:0]  ex_Dest,
  output logic        hazard_stall,
  output logic [15:0] stall_count
);

  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [31:0] rf_q [32];

  logic [31:0] read_data1_q, read_data1_d;
  logic [31:0] read_data2_q, read_data2_d;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_mem_read_q, ex_mem_read_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic        wr_en;
  logic        fwd1, fwd2;
  logic [31:0] op1, op2;

  assign wr_en = RegWrite && (Write_register != 5'd0);
  assign fwd1  = (BYPASS != 0) && wr_en && (Write_register == Read_register1);
  assign fwd2  = (BYPASS != 0) && wr_en && (Write_register == Read_register2);

  always_comb begin
    op1 = rf_q[Read_register1];
    op2 = rf_q[Read_register2];
    if (fwd1) op1 = Write_data;
    if (fwd2) op2 = Write_data;
  end

  assign hazard_stall = ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0) && id_valid &&
                        ((ex_dest_q == Read_register1) || (ex_dest_q == Read_register2));

  always_comb begin
    read_data1_d  = read_data1_q;
    read_data2_d  = read_data2_q;
    ex_valid_d    = ex_valid_q;
    ex_mem_read_d = ex_mem_read_q;
    ex_dest_d     = ex_dest_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      ex_valid_d    = 1'b0;
      ex_mem_read_d = 1'b0;
      ex_dest_d     = 5'd0;
    end else if (hazard_stall) begin
      ex_valid_d    = 1'b0;
      ex_mem_read_d = 1'b0;
      ex_dest_d     = 5'd0;
      if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
    end else begin
      ex_valid_d    = id_valid;
      ex_mem_read_d = id_MemRead && id_valid;
      ex_dest_d     = id_valid ? id_Dest : 5'd0;
      read_data1_d  = op1;
      read_data2_d  = op2;
    end
  end

  // Write-back is independent of flush/stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[Write_register] <= Write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data1_q  <= '0;
      read_data2_q  <= '0;
      ex_valid_q    <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_dest_q     <= '0;
      stall_count_q <= '0;
    end else begin
      read_data1_q  <= read_data1_d;
      read_data2_q  <= read_data2_d;
      ex_valid_q    <= ex_valid_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_dest_q     <= ex_dest_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign Read_data1  = read_data1_q;
  assign Read_data2  = read_data2_q;
  assign ex_valid    = ex_valid_q;
  assign ex_MemRead  = ex_mem_read_q;
  assign ex_Dest     = ex_dest_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_register_read.sv
// Randomized bench for register_read: a behavioural model of the register file and ID/EX
// latch is compared every cycle; directed sequences pin forwarding, r0, load-use and reset.
module tb_register_read;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite = 1'b0;
  logic [4:0]  Write_register = '0;
  logic [31:0] Write_data = '0;
  logic        id_valid = 1'b0;
  logic [4:0]  Read_register1 = '0;
  logic [4:0]  Read_register2 = '0;
  logic        id_MemRead = 1'b0;
  logic [4:0]  id_Dest = '0;
  logic        flush = 1'b0;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        ex_valid, ex_mem_read, hazard_stall;
  logic [4:0]  ex_dest;
  logic [15:0] stall_count;
  logic        nb_ex_valid, nb_ex_mem_read, nb_hazard;
  logic [4:0]  nb_ex_dest;
  logic [15:0] nb_stall_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  register_read #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .id_valid(id_valid), .Read_register1(Read_register1),
    .Read_register2(Read_register2), .id_MemRead(id_MemRead), .id_Dest(id_Dest),
    .flush(flush), .Read_data1(rd1), .Read_data2(rd2), .ex_valid(ex_valid),
    .ex_MemRead(ex_mem_read), .ex_Dest(ex_dest), .hazard_stall(hazard_stall),
    .stall_count(stall_count)
  );

  register_read #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .id_valid(id_valid), .Read_register1(Read_register1),
    .Read_register2(Read_register2), .id_MemRead(id_MemRead), .id_Dest(id_Dest),
    .flush(flush), .Read_data1(nb_rd1), .Read_data2(nb_rd2), .ex_valid(nb_ex_valid),
    .ex_MemRead(nb_ex_mem_read), .ex_Dest(nb_ex_dest), .hazard_stall(nb_hazard),
    .stall_count(nb_stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: architectural register array plus the EX-stage view.
  logic [31:0] m_rf [32];
  logic [31:0] m_rd1, m_rd2, m_nb_rd1, m_nb_rd2;
  logic        m_ev, m_mr;
  logic [4:0]  m_dest;
  int          m_cnt;

  function automatic logic m_hazard();
    return m_ev && m_mr && m_dest != 0 && id_valid &&
           (m_dest == Read_register1 || m_dest == Read_register2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit bypass);
    if (bypass && RegWrite && Write_register != 0 && Write_register == idx) return Write_data;
    return (idx == 0) ? 32'h0 : m_rf[idx];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_rd1 = 0; m_rd2 = 0; m_nb_rd1 = 0; m_nb_rd2 = 0;
      m_ev = 0; m_mr = 0; m_dest = 0; m_cnt = 0;
    end else begin
      logic        hz;
      logic [31:0] a, b, c, d;
      hz = m_hazard();
      a = m_read(Read_register1, 1'b1);
      b = m_read(Read_register2, 1'b1);
      c = m_read(Read_register1, 1'b0);
      d = m_read(Read_register2, 1'b0);
      if (RegWrite && Write_register != 0) m_rf[Write_register] = Write_data;
      if (flush || hz) begin
        m_ev = 0; m_mr = 0; m_dest = 0;
        if (!flush && m_cnt < 65535) m_cnt++;
      end else begin
        m_ev = id_valid; m_mr = id_valid && id_MemRead; m_dest = id_valid ? id_Dest : 5'd0;
        m_rd1 = a; m_rd2 = b; m_nb_rd1 = c; m_nb_rd2 = d;
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    chk("Read_data1", rd1, m_rd1);
    chk("Read_data2", rd2, m_rd2);
    chk("nobypass_Read_data1", nb_rd1, m_nb_rd1);
    chk("nobypass_Read_data2", nb_rd2, m_nb_rd2);
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_ev});
    chk("ex_MemRead", {31'b0, ex_mem_read}, {31'b0, m_mr});
    chk("ex_Dest", {27'b0, ex_dest}, {27'b0, m_dest});
    chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, m_hazard()});
    chk("stall_count", {16'b0, stall_count}, m_cnt[31:0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; Write_register = 0; Write_data = 0; id_valid = 0;
    Read_register1 = 0; Read_register2 = 0; id_MemRead = 0; id_Dest = 0; flush = 0;
  endtask

  task automatic randomize_inputs();
    RegWrite       = ($urandom_range(0, 1) == 1);
    Write_register = 5'($urandom_range(0, 7));
    Write_data     = $urandom;
    id_valid       = ($urandom_range(0, 3) != 0);
    Read_register1 = 5'($urandom_range(0, 7));
    Read_register2 = 5'($urandom_range(0, 7));
    id_MemRead     = ($urandom_range(0, 1) == 1);
    id_Dest        = 5'($urandom_range(0, 7));
    flush          = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    #1 reset = 0;
    #2;
    chk("reset_Read_data1", rd1, 32'h0);
    chk("reset_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("reset_stall_count", {16'b0, stall_count}, 32'h0);
    #20 reset = 1;
    cyc();

    // Write then read r5.
    RegWrite = 1; Write_register = 5; Write_data = 32'hDEADBEEF;
    cyc();
    idle(); id_valid = 1; Read_register1 = 5;
    cyc();
    chk("write_then_read_r5", rd1, 32'hDEADBEEF);

    // Same-cycle write/read of r7 with and without forwarding.
    idle(); RegWrite = 1; Write_register = 7; Write_data = 32'h11111111;
    cyc();
    idle(); RegWrite = 1; Write_register = 7; Write_data = 32'h12345678;
    id_valid = 1; Read_register2 = 7;
    cyc();
    chk("bypass_r7", rd2, 32'h12345678);
    chk("nobypass_r7", nb_rd2, 32'h11111111);

    // r0 writes are dropped.
    idle(); RegWrite = 1; Write_register = 0; Write_data = 32'hFFFFFFFF;
    cyc();
    idle(); id_valid = 1;
    cyc();
    chk("r0_rs", rd1, 32'h0);
    chk("r0_rt", rd2, 32'h0);

    // Load to r8 followed by a dependent read.
    idle(); id_valid = 1; id_MemRead = 1; id_Dest = 8; Read_register1 = 1; Read_register2 = 2;
    cyc();
    chk("load_in_ex_dest", {27'b0, ex_dest}, 32'd8);
    idle(); id_valid = 1; id_Dest = 3; Read_register1 = 8;
    #1 chk("load_use_stall", {31'b0, hazard_stall}, 32'd1);
    cyc();
    chk("bubble_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("bubble_stall_count", {16'b0, stall_count}, 32'd1);
    chk("stall_one_cycle", {31'b0, hazard_stall}, 32'd0);
    cyc();
    chk("advance_after_stall", {31'b0, ex_valid}, 32'd1);
    chk("advance_dest", {27'b0, ex_dest}, 32'd3);

    // Flush coincident with a hazard.
    idle(); id_valid = 1; id_MemRead = 1; id_Dest = 9;
    cyc();
    idle(); id_valid = 1; id_Dest = 4; Read_register1 = 9; flush = 1;
    #1 chk("flush_hazard_seen", {31'b0, hazard_stall}, 32'd1);
    cyc();
    chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_no_count", {16'b0, stall_count}, 32'd1);
    idle();

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cyc();
    end

    // Asynchronous reset between clock edges, with state nonzero.
    idle(); RegWrite = 1; Write_register = 5; Write_data = 32'hCAFEF00D;
    id_valid = 1; id_MemRead = 1; id_Dest = 6;
    cyc();
    id_MemRead = 0; RegWrite = 0; Read_register1 = 6; Read_register2 = 5;
    #1 reset = 0;
    #1;
    chk("async_rst_hazard", {31'b0, hazard_stall}, 32'd0);
    chk("async_rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("async_rst_ex_dest", {27'b0, ex_dest}, 32'd0);
    chk("async_rst_count", {16'b0, stall_count}, 32'd0);
    chk("async_rst_rd1", rd1, 32'h0);
    @(negedge clk);
    #1 reset = 1;
    idle(); id_valid = 1; Read_register1 = 5; Read_register2 = 7;
    cyc();
    chk("post_reset_r5", rd1, 32'h0);
    chk("post_reset_r7", rd2, 32'h0);
    chk("post_reset_advance", {31'b0, ex_valid}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      cyc();
    end
    idle();
    cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
